// File: rtl/game_control_pkg.sv
// Shared Pong geometry, score limits and referee state encoding.
// Also used by the image, ball-position and paddle blocks.
package game_control_pkg;

    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned BALL_SIZE   = 8;
    localparam int unsigned PADDLE_H    = 64;
    localparam int unsigned PADDLE_W    = 8;
    localparam int unsigned PADDLE_XL   = 16;
    localparam int unsigned PADDLE_XR   = 616;
    localparam int unsigned WIN_SCORE   = 7;
    localparam int unsigned HOLD_FRAMES = 60;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned GEO_W   = 11;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned HOLD_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    typedef struct packed {
        logic hov_l;
        logic vov_l;
        logic hov_r;
        logic vov_r;
        logic goal_l;
        logic goal_r;
    } geo_t;

    // Overlap and goal tests, widened to 11 bits so posx+BALL_SIZE cannot wrap.
    function automatic geo_t geo_eval(input logic [POS_W-1:0] px,
                                      input logic [POS_W-1:0] py,
                                      input logic [POS_W-1:0] pl,
                                      input logic [POS_W-1:0] pr);
        logic [GEO_W-1:0] bx;
        logic [GEO_W-1:0] by;
        logic [GEO_W-1:0] yl;
        logic [GEO_W-1:0] yr;
        geo_t g;
        bx = GEO_W'(px);
        by = GEO_W'(py);
        yl = GEO_W'(pl);
        yr = GEO_W'(pr);
        g.vov_l  = (by + GEO_W'(BALL_SIZE) > yl) && (by < yl + GEO_W'(PADDLE_H));
        g.vov_r  = (by + GEO_W'(BALL_SIZE) > yr) && (by < yr + GEO_W'(PADDLE_H));
        g.hov_l  = (bx < GEO_W'(PADDLE_XL + PADDLE_W)) && (bx + GEO_W'(BALL_SIZE) > GEO_W'(PADDLE_XL));
        g.hov_r  = (bx < GEO_W'(PADDLE_XR + PADDLE_W)) && (bx + GEO_W'(BALL_SIZE) > GEO_W'(PADDLE_XR));
        g.goal_r = (bx < GEO_W'(PADDLE_XL)) && !(g.hov_l && g.vov_l);
        g.goal_l = (bx + GEO_W'(BALL_SIZE) > GEO_W'(PADDLE_XR + PADDLE_W)) && !(g.hov_r && g.vov_r);
        return g;
    endfunction

endpackage

// File: rtl/game_control_rise_detect.sv
// Registered rising-edge detector; rise_c is high in the cycle d first goes high.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise_c = d & ~d_q;

endmodule

// File: rtl/game_control.sv
// Pong referee: per-frame contact/goal detection, scoring and the
// serve / point-hold / game-over sequence driving the ball block.
module game_control
    import game_control_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [POS_W-1:0] posx,
    input  logic [POS_W-1:0] posy,
    input  logic [POS_W-1:0] posbarraiy,
    input  logic [POS_W-1:0] posbarrady,
    input  logic             serve,
    output logic             ball_run,
    output logic             ball_rst,
    output logic             serve_dir,
    output logic             hit_l,
    output logic             hit_r,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic             game_over,
    output logic             winner
);

    state_t              state, state_nx;
    logic [HOLD_W-1:0]   hold, hold_nx;
    logic                flag_l, flag_l_nx;
    logic                flag_r, flag_r_nx;
    logic [SCORE_W-1:0]  score_l_nx, score_r_nx;
    logic                ball_rst_nx, serve_dir_nx, hit_l_nx, hit_r_nx, winner_nx;
    logic                serve_rise_c;
    geo_t                geo_c;

    rise_detect u_serve_rise (
        .clk    (clk),
        .rst_n  (reset),
        .d      (serve),
        .rise_c (serve_rise_c)
    );

    assign geo_c = geo_eval(posx, posy, posbarraiy, posbarrady);

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        hold_nx      = hold;
        flag_l_nx    = flag_l;
        flag_r_nx    = flag_r;
        score_l_nx   = score_l;
        score_r_nx   = score_r;
        serve_dir_nx = serve_dir;
        winner_nx    = winner;
        ball_rst_nx  = 1'b0;
        hit_l_nx     = 1'b0;
        hit_r_nx     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (serve_rise_c) state_nx = ST_SERVE;
            end
            ST_SERVE: begin
                if (serve_rise_c) state_nx = ST_PLAY;
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (!geo_c.hov_l) begin
                        flag_l_nx = 1'b0;
                    end else if (geo_c.vov_l && !flag_l) begin
                        flag_l_nx = 1'b1;
                        hit_l_nx  = 1'b1;
                    end
                    if (!geo_c.hov_r) begin
                        flag_r_nx = 1'b0;
                    end else if (geo_c.vov_r && !flag_r) begin
                        flag_r_nx = 1'b1;
                        hit_r_nx  = 1'b1;
                    end
                    // A contact pulse in this frame suppresses any goal.
                    if (!(hit_l_nx || hit_r_nx) && (geo_c.goal_r || geo_c.goal_l)) begin
                        if (geo_c.goal_r) begin
                            if (score_r != SCORE_W'(WIN_SCORE)) score_r_nx = score_r + SCORE_W'(1);
                            serve_dir_nx = 1'b0;
                        end else begin
                            if (score_l != SCORE_W'(WIN_SCORE)) score_l_nx = score_l + SCORE_W'(1);
                            serve_dir_nx = 1'b1;
                        end
                        ball_rst_nx = 1'b1;
                        hold_nx     = '0;
                        state_nx    = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (hold == HOLD_W'(HOLD_FRAMES - 1)) begin
                        if (score_l == SCORE_W'(WIN_SCORE) || score_r == SCORE_W'(WIN_SCORE)) begin
                            winner_nx = (score_r == SCORE_W'(WIN_SCORE));
                            state_nx  = ST_OVER;
                        end else begin
                            state_nx  = ST_SERVE;
                        end
                    end else begin
                        hold_nx = hold + HOLD_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (serve_rise_c) begin
                    score_l_nx  = '0;
                    score_r_nx  = '0;
                    ball_rst_nx = 1'b1;
                    state_nx    = ST_SERVE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            hold      <= '0;
            flag_l    <= 1'b0;
            flag_r    <= 1'b0;
            score_l   <= '0;
            score_r   <= '0;
            serve_dir <= 1'b0;
            winner    <= 1'b0;
            ball_rst  <= 1'b0;
            hit_l     <= 1'b0;
            hit_r     <= 1'b0;
            ball_run  <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nx;
            hold      <= hold_nx;
            flag_l    <= flag_l_nx;
            flag_r    <= flag_r_nx;
            score_l   <= score_l_nx;
            score_r   <= score_r_nx;
            serve_dir <= serve_dir_nx;
            winner    <= winner_nx;
            ball_rst  <= ball_rst_nx;
            hit_l     <= hit_l_nx;
            hit_r     <= hit_r_nx;
            ball_run  <= (state_nx == ST_PLAY);
            game_over <= (state_nx == ST_OVER);
        end
    end

endmodule

// File: tb/tb_game_control.sv
// Scoreboard bench for game_control: stimulus queues expected output events,
// a negedge monitor pops and compares whenever a pulse fires or a level changes.
module tb_game_control;

    typedef struct packed {
        logic       ball_run;
        logic       ball_rst;
        logic       serve_dir;
        logic       hit_l;
        logic       hit_r;
        logic [3:0] score_l;
        logic [3:0] score_r;
        logic       game_over;
        logic       winner;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] posx = 10'd300;
    logic [9:0] posy = 10'd200;
    logic [9:0] posbarraiy = 10'd100;
    logic [9:0] posbarrady = 10'd100;
    logic       ball_run, ball_rst, serve_dir, hit_l, hit_r, game_over, winner;
    logic [3:0] score_l, score_r;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    obs_t exp_q[$];
    int   cyc_q[$];
    obs_t m = '0;
    logic [11:0] lv_prev = '0;

    game_control dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .posx       (posx),
        .posy       (posy),
        .posbarraiy (posbarraiy),
        .posbarrady (posbarrady),
        .serve      (serve),
        .ball_run   (ball_run),
        .ball_rst   (ball_rst),
        .serve_dir  (serve_dir),
        .hit_l      (hit_l),
        .hit_r      (hit_r),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t cur_obs();
        obs_t o;
        o = {ball_run, ball_rst, serve_dir, hit_l, hit_r, score_l, score_r, game_over, winner};
        return o;
    endfunction

    function automatic obs_t rec(input bit rst, input bit hl, input bit hr);
        obs_t r;
        r = m;
        r.ball_rst = rst;
        r.hit_l = hl;
        r.hit_r = hr;
        return r;
    endfunction

    // Monitor: any pulse or level change is a presented event.
    always @(negedge clk) begin : monitor
        logic [11:0] lv;
        obs_t o, e;
        int c;
        lv = {ball_run, serve_dir, score_l, score_r, game_over, winner};
        o = cur_obs();
        if (reset && (hit_l || hit_r || ball_rst || lv != lv_prev)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d got=%h", cyc, o);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                if (o !== e || cyc != c) begin
                    failures++;
                    $display("FAIL event cyc=%0d got=%h required=%h at cyc=%0d", cyc, o, e, c);
                end
            end
        end
        lv_prev = lv;
    end

    task automatic push(input obs_t e);
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1);
    endtask

    task automatic tick(input bit has, input obs_t e);
        @(negedge clk);
        frame_tick = 1'b1;
        if (has) push(e);
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input bit has, input obs_t e);
        @(negedge clk);
        serve = 1'b1;
        if (has) push(e);
        @(negedge clk);
        serve = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending_events=%0d required=0", name, exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic check_direct(input string name, input obs_t req);
        checks++;
        if (cur_obs() !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, cur_obs(), req);
        end
    endtask

    // Scoring frame, then optionally the full 60-tick hold and the next serve.
    task automatic do_goal(input bit left_scores, input bit full);
        if (left_scores) begin
            posx = 10'd630; posy = 10'd200; posbarrady = 10'd100;
            if (m.score_l < 4'd7) m.score_l = m.score_l + 4'd1;
            m.serve_dir = 1'b1;
        end else begin
            posx = 10'd10; posy = 10'd200; posbarraiy = 10'd100;
            if (m.score_r < 4'd7) m.score_r = m.score_r + 4'd1;
            m.serve_dir = 1'b0;
        end
        m.ball_run = 1'b0;
        tick(1'b1, rec(1'b1, 1'b0, 1'b0));
        posx = 10'd300;
        if (full) begin
            for (int i = 0; i < 59; i++) tick(1'b0, '0);
            press(1'b0, '0);
            if (m.score_l == 4'd7 || m.score_r == 4'd7) begin
                m.game_over = 1'b1;
                m.winner = (m.score_r == 4'd7);
                tick(1'b1, rec(1'b0, 1'b0, 1'b0));
            end else begin
                tick(1'b0, '0);
                m.ball_run = 1'b1;
                press(1'b1, rec(1'b0, 1'b0, 1'b0));
            end
        end
        drain("goal_seq");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_direct("reset_state", '0);
        reset = 1'b1;
        @(negedge clk);
        check_direct("after_release", '0);

        // IDLE -> SERVE -> PLAY
        press(1'b0, '0);
        m.ball_run = 1'b1;
        press(1'b1, rec(1'b0, 1'b0, 1'b0));
        drain("serve_to_play");

        // Left paddle contact held for 3 frames, release, re-contact
        posx = 10'd20; posy = 10'd120; posbarraiy = 10'd100; posbarrady = 10'd300;
        tick(1'b1, rec(1'b0, 1'b1, 1'b0));
        tick(1'b0, '0);
        tick(1'b0, '0);
        posx = 10'd40;
        tick(1'b0, '0);
        posx = 10'd20;
        tick(1'b1, rec(1'b0, 1'b1, 1'b0));
        posx = 10'd300;
        tick(1'b0, '0);
        // Right paddle contact
        posx = 10'd610; posbarrady = 10'd100;
        tick(1'b1, rec(1'b0, 1'b0, 1'b1));
        posx = 10'd300;
        tick(1'b0, '0);
        drain("hits");

        // Right scores, full 60-tick hold with ignored serve
        do_goal(1'b0, 1'b1);

        // Left scores to 7 -> OVER
        for (int g = 0; g < 7; g++) do_goal(1'b1, 1'b1);

        // Goal-position frames in OVER change nothing
        posx = 10'd630;
        tick(1'b0, '0);
        posx = 10'd5;
        tick(1'b0, '0);
        posx = 10'd300;
        m.score_l = '0; m.score_r = '0; m.game_over = 1'b0;
        press(1'b1, rec(1'b1, 1'b0, 1'b0));
        drain("over_restart");

        // Back to play, right to 3, reset mid-hold
        m.ball_run = 1'b1;
        press(1'b1, rec(1'b0, 1'b0, 1'b0));
        do_goal(1'b0, 1'b1);
        do_goal(1'b0, 1'b1);
        do_goal(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, '0);
        check_direct("score_before_reset", rec(1'b0, 1'b0, 1'b0));
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_direct("async_reset", '0);
        m = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_direct("post_reset_idle", '0);
        press(1'b0, '0);
        drain("idle_first_serve");
        m.ball_run = 1'b1;
        press(1'b1, rec(1'b0, 1'b0, 1'b0));
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
